// File: rtl/mips_mc_controller.sv
// Multicycle control unit for the 8-bit MIPS datapath: a Moore FSM for datapath controls plus combinational ALU decode.
// Optional addi support is built when MIPS_ADDI_EN is defined.
module mips_mc_controller #(
    parameter int FETCH_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   memread,
    output logic                   memwrite,
    output logic                   iord,
    output logic [FETCH_BYTES-1:0] irwrite,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             pcsource,
    output logic                   pcen,
    output logic [2:0]             alucont
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
        SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
    } state_t;

    state_t                   state, next_state;
    logic                     pcwrite, branch;
    logic                     memwrite_raw, regwrite_raw;
    logic [FETCH_BYTES-1:0]   irwrite_raw;
    logic [1:0]               aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH1;
        case (state)
            FETCH1:  next_state = FETCH2;
            FETCH2:  next_state = FETCH3;
            FETCH3:  next_state = FETCH4;
            FETCH4:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      next_state = ADDIEX;
`endif
                    default:      next_state = FETCH1;
                endcase
            end
            MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    next_state = LBWR;
            RTYPEEX: next_state = RTYPEWR;
`ifdef MIPS_ADDI_EN
            ADDIEX:  next_state = ADDIWR;
`endif
            default: next_state = FETCH1;
        endcase
    end

    always_comb begin
        memread      = 1'b0;
        memwrite_raw = 1'b0;
        iord         = 1'b0;
        irwrite_raw  = '0;
        regwrite_raw = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsource     = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                case (state)
                    FETCH1:  irwrite_raw[0] = 1'b1;
                    FETCH2:  irwrite_raw[1] = 1'b1;
                    FETCH3:  irwrite_raw[2] = 1'b1;
                    default: irwrite_raw[3] = 1'b1;
                endcase
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            SBWR: begin
                memwrite_raw = 1'b1;
                iord         = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWR: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
                pcsource = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIWR:  regwrite_raw = 1'b1;
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH1, whose strobes must not disturb PC, IR or memory.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = reset ? '0 : irwrite_raw;
    assign memwrite = ~reset & memwrite_raw;
    assign regwrite = ~reset & regwrite_raw;

    always_comb begin
        alucont = 3'b010;
        case (aluop)
            2'b00: alucont = 3'b010;
            2'b01: alucont = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alucont = 3'b010;
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b101;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized and directed bench for mips_mc_controller against a per-instruction cycle-table model.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       memread, memwrite, iord, regwrite, regdst, memtoreg, alusrca, pcen;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucont;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       memread, memwrite, iord;
        logic [3:0] irwrite;
        logic       regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic       pcen;
        logic [2:0] alucont;
    } ctl_t;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsource(pcsource), .pcen(pcen), .alucont(alucont)
    );

    always #5 clk = ~clk;

    function automatic bit addi_en();
`ifdef MIPS_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycles from one FETCH1 to the next, straight from the instruction latency table.
    function automatic int latency(input logic [5:0] o);
        case (o)
            6'b100000: return 8;
            6'b101000: return 7;
            6'b000000: return 7;
            6'b000100: return 6;
            6'b000010: return 6;
            6'b001000: return addi_en() ? 7 : 5;
            default:   return 5;
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b101;
        endcase
    endfunction

    // Expected controls at cycle k of an instruction: four fetches, decode, then the op's own steps.
    function automatic ctl_t expect_ctl(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
        ctl_t e;
        e = '0;
        e.alucont = 3'b010;
        if (k < 4) begin
            e.memread = 1'b1;
            e.irwrite = 4'b0001 << k;
            e.alusrcb = 2'b01;
            e.pcen    = 1'b1;
        end else if (k == 4) begin
            e.alusrcb = 2'b11;
        end else if (o == 6'b100000 || o == 6'b101000) begin
            if (k == 5) begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
            end else if (o == 6'b100000 && k == 6) begin
                e.memread = 1'b1;
                e.iord    = 1'b1;
            end else if (o == 6'b100000) begin
                e.regwrite = 1'b1;
                e.memtoreg = 1'b1;
            end else begin
                e.memwrite = 1'b1;
                e.iord     = 1'b1;
            end
        end else if (o == 6'b000000) begin
            if (k == 5) begin
                e.alusrca = 1'b1;
                e.alucont = funct_op(f);
            end else begin
                e.regwrite = 1'b1;
                e.regdst   = 1'b1;
            end
        end else if (o == 6'b000100) begin
            e.alusrca  = 1'b1;
            e.alucont  = 3'b110;
            e.pcsource = 2'b01;
            e.pcen     = z;
        end else if (o == 6'b000010) begin
            e.pcen     = 1'b1;
            e.pcsource = 2'b10;
        end else if (o == 6'b001000) begin
            if (k == 5) begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
            end else begin
                e.regwrite = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic ctl_t observed();
        return {memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsource, pcen, alucont};
    endfunction

    task automatic test_reset();
        ctl_t got, e;
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b1;
        e = expect_ctl(6'b0, 6'b0, 1'b1, 0);
        e.irwrite = 4'b0000;
        e.pcen    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h expected=%h", c, got, e);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== expect_ctl(6'b0, 6'b0, 1'b1, 0)) begin
            failures++;
            $display("FAIL reset_release_fetch1 got=%h expected=%h", got, expect_ctl(6'b0, 6'b0, 1'b1, 0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic test_rtype();
        ctl_t got, e;
        logic [5:0] fl [6] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
        op = 6'b000000;
        foreach (fl[i]) begin
            funct = fl[i];
            for (int k = 0; k < latency(op); k++) begin
                zero = 1'($urandom);
                @(negedge clk);
                got = observed();
                e = expect_ctl(op, funct, zero, k);
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL rtype funct=%b k=%0d got=%h expected=%h", funct, k, got, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_beq();
        ctl_t got, e;
        op = 6'b000100; funct = 6'b0;
        for (int z = 1; z >= 0; z--) begin
            for (int k = 0; k < latency(op); k++) begin
                zero = (k == 5) ? 1'(z) : 1'($urandom);
                @(negedge clk);
                got = observed();
                e = expect_ctl(op, funct, zero, k);
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL beq zero=%0d k=%0d got=%h expected=%h", z, k, got, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lb_sb_unknown();
        ctl_t got, e;
        logic [5:0] ol [5] = '{6'b100000, 6'b101000, 6'b111111, 6'b001000, 6'b000010};
        foreach (ol[i]) begin
            op = ol[i]; funct = 6'($urandom);
            for (int k = 0; k < latency(op); k++) begin
                zero = 1'($urandom);
                @(negedge clk);
                got = observed();
                e = expect_ctl(op, funct, zero, k);
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL opcode op=%b k=%0d got=%h expected=%h", op, k, got, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mid_reset();
        ctl_t got, e;
        op = 6'b100000; funct = 6'b0; zero = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        // now sitting in LBRD; assert reset between edges
        #2 reset = 1'b1;
        #1;
        got = observed();
        e = expect_ctl(op, funct, zero, 0);
        e.irwrite = 4'b0000;
        e.pcen    = 1'b0;
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL mid_reset got=%h expected=%h", got, e);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== expect_ctl(op, funct, zero, 0)) begin
            failures++;
            $display("FAIL mid_reset_restart got=%h expected=%h", got, expect_ctl(op, funct, zero, 0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic test_random();
        ctl_t got, e;
        logic [5:0] ol [7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ol[$urandom_range(0, 6)];
            funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
            for (int k = 0; k < latency(op); k++) begin
                zero = 1'($urandom);
                @(negedge clk);
                got = observed();
                e = expect_ctl(op, funct, zero, k);
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL random n=%0d op=%b funct=%b k=%0d got=%h expected=%h", n, op, funct, k, got, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_beq();
        test_lb_sb_unknown();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
